// File: rtl/button_event_queue_pkg.sv
`default_nettype none
// ============================================================================
// button_pkg: shared defaults and one-hot helpers for button_event_queue
// Rev 1.0
// ============================================================================
package button_pkg;

    localparam int NBTN_DEFAULT  = 4;
    localparam int DEPTH_DEFAULT = 4;
    localparam int BTN_MAX       = 16;
    localparam int IDX_MAX_W     = 4;

    // Two's-complement trick isolates the lowest set bit.
    function automatic logic [BTN_MAX-1:0] lsb_onehot(input logic [BTN_MAX-1:0] v);
        return v & (~v + BTN_MAX'(1));
    endfunction

    function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [BTN_MAX-1:0] oh);
        logic [IDX_MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < BTN_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_MAX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_queue_if.sv
`default_nettype none
// ============================================================================
// button_event_queue_if: valid/ready event stream toward the input consumer
// Rev 1.0
// ============================================================================
interface button_event_queue_if #(
    parameter int CW = 2
);
    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] evt_code;

    modport master (
        output evt_valid,
        output evt_code,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        output evt_ready
    );
endinterface
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// ============================================================================
// event_fifo: synchronous show-ahead FIFO; write into full allowed with a pop
// Rev 1.0
// ============================================================================
module event_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             wr_en,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             rd_en,
    output logic      [WIDTH-1:0] rd_data,
    output logic      [CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_do_wr;
    logic             w_do_rd;

    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Storage is reset too so the head reads a defined code straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_event_queue.sv
`default_nettype none
// ============================================================================
// button_event_queue: serializes debounced press pulses into an event FIFO
// Rev 1.0
// ============================================================================
module button_event_queue
    import button_pkg::*;
#(
    parameter int NBTN  = NBTN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int CW    = $clog2(NBTN),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [NBTN-1:0]  btn_pulse,
    button_event_queue_if.master  evt,
    output logic      [CNT_W-1:0] count,
    output logic                  overflow,
    input  wire logic             ovf_clr
);

    logic [NBTN-1:0] pending_q;
    logic [NBTN-1:0] pending_d;
    logic            overflow_q;
    logic            overflow_d;
    logic [NBTN-1:0] w_cand;
    logic [NBTN-1:0] w_grant;
    logic [CW-1:0]   w_wr_code;
    logic            w_pop;
    logic            w_wr_ok;
    logic            w_full;
    logic            w_empty;
    logic            w_merge_loss;

    assign w_cand  = pending_q | btn_pulse;
    assign w_pop   = ~w_empty & evt.evt_ready;
    assign w_wr_ok = ~w_full | w_pop;

    assign w_grant   = w_wr_ok ? NBTN'(lsb_onehot(BTN_MAX'(w_cand))) : '0;
    assign w_wr_code = CW'(onehot_to_idx(BTN_MAX'(w_grant)));

    // A repeat pulse on a still-pending bit collapses into the earlier press.
    assign w_merge_loss = |(btn_pulse & pending_q & ~w_grant);

    assign pending_d  = w_cand & ~w_grant;
    assign overflow_d = (overflow_q & ~ovf_clr) | w_merge_loss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow      = overflow_q;
    assign evt.evt_valid = ~w_empty;

    event_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (|w_grant),
        .wr_data (w_wr_code),
        .rd_en   (w_pop),
        .rd_data (evt.evt_code),
        .count   (count),
        .full    (w_full),
        .empty   (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_button_event_queue.sv
`default_nettype none
// ============================================================================
// tb_button_event_queue: table vectors, reset corner case and random traffic
// Rev 1.0
// ============================================================================
module tb_button_event_queue;
    import button_pkg::*;

    localparam int NBTN  = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NBTN-1:0] btn_pulse = '0;
    logic            ovf_clr = 1'b0;
    logic [2:0]      count;
    logic            overflow;

    button_event_queue_if #(.CW(CW)) evt ();

    button_event_queue #(
        .NBTN  (NBTN),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pulse (btn_pulse),
        .evt       (evt),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: event queue, pending press set and sticky loss flag.
    int        mq[$];
    logic [3:0] m_pend = '0;
    logic       m_ovf  = 1'b0;

    typedef struct {
        logic [3:0] p;
        logic       r;
        logic       c;
        logic       v;
        logic [1:0] code;
        logic [2:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] p, input logic r, input logic c, input logic v,
                       input logic [1:0] code, input logic [2:0] cnt, input logic ovf);
        vec_t t;
        t.p = p; t.r = r; t.c = c; t.v = v; t.code = code; t.cnt = cnt; t.ovf = ovf;
        tbl.push_back(t);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] p, input logic r, input logic c);
        logic [3:0] cand;
        logic [3:0] grant;
        bit         pop;
        bit         wr_ok;
        int         g;
        pop   = (mq.size() > 0) && (r == 1'b1);
        wr_ok = (mq.size() < DEPTH) || pop;
        cand  = m_pend | p;
        grant = '0;
        g     = -1;
        if (wr_ok) begin
            for (int i = 0; i < NBTN; i++) begin
                if (cand[i] && g < 0) g = i;
            end
        end
        if (g >= 0) grant[g] = 1'b1;
        m_ovf  = (m_ovf && !c) || (|(p & m_pend & ~grant));
        m_pend = cand & ~grant;
        if (pop) void'(mq.pop_front());
        if (g >= 0) mq.push_back(g);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " valid"}, 16'(evt.evt_valid), 16'(mq.size() > 0));
        chk({tag, " count"}, 16'(count), 16'(mq.size()));
        chk({tag, " overflow"}, 16'(overflow), 16'(m_ovf));
        if (mq.size() > 0) chk({tag, " code"}, 16'(evt.evt_code), 16'(mq[0]));
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic cycle(input logic [3:0] p, input logic r, input logic c, input string tag);
        btn_pulse     = p;
        evt.evt_ready = r;
        ovf_clr       = c;
        #1;
        check_model(tag);
        @(posedge clk);
        model_step(p, r, c);
        @(negedge clk);
    endtask

    initial begin
        evt.evt_ready = 1'b0;
        // single press, simultaneous presses
        add(4'b0000,1,0, 0,0,0,0); add(4'b0100,1,0, 0,0,0,0); add(4'b0000,1,0, 1,2,1,0);
        add(4'b0000,1,0, 0,0,0,0); add(4'b1011,1,0, 0,0,0,0); add(4'b0000,1,0, 1,0,1,0);
        add(4'b0000,1,0, 1,1,1,0); add(4'b0000,1,0, 1,3,1,0); add(4'b0000,1,0, 0,0,0,0);
        // backpressure fill, waiting 5th press, merge loss, clear vs. set
        add(4'b0001,0,0, 0,0,0,0); add(4'b0010,0,0, 1,0,1,0); add(4'b0100,0,0, 1,0,2,0);
        add(4'b1000,0,0, 1,0,3,0); add(4'b0001,0,0, 1,0,4,0); add(4'b0010,0,0, 1,0,4,0);
        add(4'b0010,0,0, 1,0,4,0); add(4'b0010,0,1, 1,0,4,1); add(4'b0000,0,1, 1,0,4,1);
        add(4'b0000,0,0, 1,0,4,0);
        // drain while full with a new press: 0,1,2,3 then 0, one 1, then 3
        add(4'b1000,1,0, 1,0,4,0); add(4'b0000,1,0, 1,1,4,0); add(4'b0000,1,0, 1,2,4,0);
        add(4'b0000,1,0, 1,3,4,0); add(4'b0000,1,0, 1,0,3,0); add(4'b0000,1,0, 1,1,2,0);
        add(4'b0000,1,0, 1,3,1,0); add(4'b0000,1,0, 0,0,0,0);
        // full FIFO with coincident pop and pulse keeps count at 4
        add(4'b0001,0,0, 0,0,0,0); add(4'b0010,0,0, 1,0,1,0); add(4'b0100,0,0, 1,0,2,0);
        add(4'b1000,0,0, 1,0,3,0); add(4'b1000,1,0, 1,0,4,0); add(4'b0000,1,0, 1,1,4,0);
        add(4'b0000,1,0, 1,2,3,0); add(4'b0000,1,0, 1,3,2,0); add(4'b0000,1,0, 1,3,1,0);
        add(4'b0000,1,0, 0,0,0,0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset valid", 16'(evt.evt_valid), 16'd0);
        chk("reset count", 16'(count), 16'd0);
        chk("reset overflow", 16'(overflow), 16'd0);
        chk("reset code", 16'(evt.evt_code), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        foreach (tbl[k]) begin
            btn_pulse     = tbl[k].p;
            evt.evt_ready = tbl[k].r;
            ovf_clr       = tbl[k].c;
            #1;
            chk($sformatf("vec%0d valid", k), 16'(evt.evt_valid), 16'(tbl[k].v));
            chk($sformatf("vec%0d count", k), 16'(count), 16'(tbl[k].cnt));
            chk($sformatf("vec%0d overflow", k), 16'(overflow), 16'(tbl[k].ovf));
            if (tbl[k].v) chk($sformatf("vec%0d code", k), 16'(evt.evt_code), 16'(tbl[k].code));
            check_model($sformatf("vec%0d model", k));
            @(posedge clk);
            model_step(tbl[k].p, tbl[k].r, tbl[k].c);
            @(negedge clk);
        end

        // Build count=3 with a press pending and overflow set, then reset mid-cycle.
        cycle(4'b0111, 1'b0, 1'b0, "pre-rst a");
        cycle(4'b0100, 1'b0, 1'b0, "pre-rst b");
        cycle(4'b1000, 1'b0, 1'b0, "pre-rst c");
        btn_pulse = '0;
        #1;
        chk("pre-rst count", 16'(count), 16'd3);
        chk("pre-rst overflow", 16'(overflow), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst valid", 16'(evt.evt_valid), 16'd0);
        chk("async rst count", 16'(count), 16'd0);
        chk("async rst overflow", 16'(overflow), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(4'b0000, 1'b1, 1'b0, $sformatf("post-rst %0d", i));
            chk($sformatf("post-rst stale %0d", i), 16'(evt.evt_valid), 16'd0);
        end

        // Random traffic with bursts of backpressure.
        for (int i = 0; i < 800; i++) begin
            logic [3:0] p;
            logic       r;
            logic       c;
            p = 4'($urandom & $urandom);
            r = ((i / 40) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            cycle(p, r, c, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_event_queue.md
# button_event_queue

Collects one-cycle press pulses from a bank of `debounce` instances and buffers them as an ordered stream of button-index events with a valid/ready handshake toward the game/control FSM. Simultaneous presses are serialized lowest-index first, and lost presses are flagged. It sits directly downstream of the per-button debouncers and upstream of whatever consumes user input.

## Interface
- `NBTN`, 4: number of button pulse inputs, range 2..16.
- `DEPTH`, 4: event FIFO depth, power of two, at least 2.
- `CW`, `$clog2(NBTN)`: event code width (derived, not overridden).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `btn_pulse`  in  NBTN: one-cycle press pulses, bit i from debouncer i. Multiple bits may be high together.
- `evt_ready`  in  1: consumer accepts the head event this cycle.
- `evt_valid`  out  1: FIFO not empty. Reset value 0.
- `evt_code`  out  CW: index of the head event. Reset value 0. Don't-care while `evt_valid`=0.
- `count`  out  `$clog2(DEPTH)+1`: number of events held in the FIFO. Reset value 0.
- `overflow`  out  1: sticky lost-press flag. Reset value 0.
- `ovf_clr`  in  1: synchronous clear of `overflow`.

## Operation
- **pending** (NBTN bits) holds presses not yet written to the FIFO.
- `cand = pending | btn_pulse`.
- `pop = evt_valid & evt_ready`.
- `wr_ok = (count < DEPTH) | pop`. A write into a full FIFO is allowed in a cycle that also pops.
- **grant**: one-hot lowest set bit of `cand` when `wr_ok`; otherwise zero.
- **Write**: if grant is nonzero, write `CW`-bit index of the grant into the FIFO tail.
- **pending update**: `pending <= cand & ~grant`.
- **Merge loss**: a press is lost when `btn_pulse & pending & ~grant` is nonzero, i.e. a bit pulses again while its earlier press is still pending. That earlier press is kept; `overflow` is set.
- **overflow update**: `overflow <= (overflow & ~ovf_clr) | merge_loss`. If set and clear happen in the same cycle, set wins.
- **FIFO**: synchronous, show-ahead.
  - `evt_code` is driven from the head entry.
  - Pop advances the head.
  - Pointers wrap modulo DEPTH.
  - `count` is updated by +1, −1, or 0 when write and pop coincide.
- **Backpressure**: while the FIFO is full and there is no pop, grant is zero and all presses wait in pending. No press is dropped unless it merges.
- **Ordering**:
  - Events leave in write order.
  - Within one cycle's candidates, the lowest index goes first, one per cycle.
- **Reset**: asynchronous. It clears pending, the FIFO pointers, `count` and `overflow` at any time, including mid-burst. Events that were in flight are discarded.

## Timing
- **Latency**: `btn_pulse[i]` high in cycle t with an empty FIFO gives `evt_valid`=1 and `evt_code`=i in cycle t+1.
- **Throughput**: one write and one pop per cycle. When presses are already pending, a pulse in cycle t is written no earlier than the cycle its grant is reached.
- **k simultaneous pulses**, empty FIFO, consumer always ready: events appear in cycles t+1 through t+k, in ascending index order.
- `evt_code` is stable while `evt_valid`=1 and `evt_ready`=0.
- `count` and `overflow` are registered outputs. `evt_code` is read combinationally from FIFO storage at the head pointer.

## Structure
- **Package `button_pkg`**:
  - default `NBTN` and `DEPTH` localparams;
  - a lowest-set-bit one-hot function;
  - a one-hot-to-index encoder function.
- **Sub-module `event_fifo`**:
  - generic synchronous show-ahead FIFO, parameters WIDTH and DEPTH;
  - ports `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `count`, `full`, `empty`.
- **Top level** `button_event_queue` contains only the pending register, grant logic and overflow flag.

## Test plan
- **Single press, ready=1**: pulse bit 2 in cycle 5. Expect `evt_valid`=1 and `evt_code`=2 in cycle 6 only; `count` goes 0→1→0.
- **Simultaneous press**: `btn_pulse`=4'b1011 in one cycle, ready=1. Expect codes 0, 1, 3 in three consecutive cycles; `overflow`=0.
- **Backpressure, DEPTH=4, ready=0**: pulse bits 0, 1, 2, 3, then 0 again in separate cycles.
  - FIFO fills with 0, 1, 2, 3 and `count`=4.
  - The second bit-0 press waits in pending; `overflow` stays 0.
  - Raise ready: the 5th event, code 0, appears after the 4th.
- **Merge loss**: FIFO full, ready=0, pulse bit 1 twice.
  - `overflow`=1 the cycle after the second pulse.
  - On drain, only one code-1 event appears beyond the FIFO contents.
  - `ovf_clr` clears `overflow` next cycle; `ovf_clr` coinciding with a new merge leaves it 1.
- **Full with simultaneous pop and pulse**: `count`=4, ready=1, pulse bit 3. `count` stays 4; code 3 is enqueued at the tail.
- **Mid-operation reset**: assert `rst` asynchronously with `count`=3 and pending nonzero. Outputs are immediately `evt_valid`=0, `count`=0, `overflow`=0; no stale event appears after release.
